multdiv_unit: RTL and testbench

//  Iterative signed 32-bit multiply/divide unit for the processor's execute stage, alongside the single-cycle ALU.
//  The pipeline issues a one-cycle MULT or DIV request; the unit latches the operands and iterates one bit per clock.
//  It then returns a registered result with an exception flag and a one-cycle ready pulse.
//  The pipeline stalls on the ready pulse; the unit has no knowledge of the stall logic.

---
 rtl/multdiv_unit_pkg.sv | 26 ++
 rtl/multdiv_unit_cond_negate.sv | 25 ++
 rtl/multdiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_multdiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_unit_pkg.sv
// ============================================================================
//  Module      : multdiv_unit_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                FSM state encoding and the execute-stage ALU opcodes that
//                route an instruction to this unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_unit_pkg;

    // FSM state encoding (explicit 2-bit values)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ALU opcodes decoded by the execute stage to start this unit
    localparam logic [4:0] c_ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] c_ALU_OP_DIV  = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/multdiv_unit_cond_negate.sv
// ============================================================================
//  Module      : multdiv_unit_cond_negate
//  Description : Conditional two's-complement negate, data_out = neg ? -in : in.
//  Ports       : data_in  [WIDTH-1:0]  value to (maybe) negate
//                neg                   1 = negate
//                data_out [WIDTH-1:0]  result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             neg,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign data_out = neg ? ((~data_in) + c_ONE) : data_in;

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
//  Module      : multdiv_unit
//  Description : Iterative signed multiply / divide, one bit per clock.
//                Operands are converted to magnitudes at the start edge, the
//                core iterates WIDTH times (shift-add or restoring divide),
//                and a DONE cycle applies the sign and raises a one-cycle
//                ready pulse.
//  Ports       : clock           rising-edge clock
//                reset           asynchronous active-high reset
//                data_operandA   multiplicand / dividend (sampled on start)
//                data_operandB   multiplier / divisor    (sampled on start)
//                ctrl_MULT       start-multiply pulse (wins over ctrl_DIV)
//                ctrl_DIV        start-divide pulse
//                data_result     product low bits or quotient, held
//                data_exception  overflow / divide-by-zero, held
//                data_resultRDY  one-cycle result-valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [5:0]       c_LAST = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    state_t           r_state;
    logic [5:0]       r_count;
    logic             r_is_mul;
    logic             r_neg;
    logic             r_b_zero;
    // r_opnd : multiplicand magnitude (MUL) or divisor magnitude (DIV)
    // r_acc  : upper product half (MUL) or partial remainder (DIV)
    // r_lo   : multiplier shifting out / product low half (MUL), or
    //          dividend shifting out / quotient shifting in (DIV)
    logic [WIDTH:0]   r_opnd;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_ready;

    logic             w_start;
    logic [WIDTH:0]   w_mag_a;
    logic [WIDTH:0]   w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH-1:0] w_signed_lo;
    logic             w_mul_ovf;
    logic             w_div_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;

    // Magnitudes carry one extra bit so |INT_MIN| = 2^WIDTH-1 is exact.
    multdiv_unit_cond_negate #(.WIDTH(WIDTH + 1)) u_neg_a (
        .data_in  ({data_operandA[WIDTH-1], data_operandA}),
        .neg      (data_operandA[WIDTH-1]),
        .data_out (w_mag_a)
    );

    multdiv_unit_cond_negate #(.WIDTH(WIDTH + 1)) u_neg_b (
        .data_in  ({data_operandB[WIDTH-1], data_operandB}),
        .neg      (data_operandB[WIDTH-1]),
        .data_out (w_mag_b)
    );

    // Low product bits and the quotient both end up in r_lo, so one
    // negator serves both operations.
    multdiv_unit_cond_negate #(.WIDTH(WIDTH)) u_neg_res (
        .data_in  (r_lo),
        .neg      (r_neg),
        .data_out (w_signed_lo)
    );

    // Shift-add step: accumulator never exceeds WIDTH+1 bits because the
    // multiplicand magnitude is at most 2^(WIDTH-1).
    assign w_sum = r_acc + (r_lo[0] ? r_opnd : {(WIDTH+1){1'b0}});

    // Restoring-divide step: remainder < divisor <= 2^(WIDTH-1), so the
    // shifted remainder fits in WIDTH+1 bits.
    assign w_shift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, r_opnd};

    // Overflow without a 2*WIDTH negate: a negative product fits when its
    // magnitude is <= 2^(WIDTH-1), a positive one when < 2^(WIDTH-1).
    assign w_mul_ovf = (r_acc[WIDTH-1:0] != c_ZERO) ||
                       (r_neg ? (r_lo[WIDTH-1] && (r_lo[WIDTH-2:0] != c_ZERO[WIDTH-2:0]))
                              : r_lo[WIDTH-1]);

    // A positive quotient with the top bit set only arises from INT_MIN / -1.
    assign w_div_exc = r_b_zero || (!r_neg && r_lo[WIDTH-1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_is_mul    <= 1'b0;
            r_neg       <= 1'b0;
            r_b_zero    <= 1'b0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_start) begin
                // A start always aborts whatever is in flight.
                r_state  <= ctrl_MULT ? ST_MUL : ST_DIV;
                r_is_mul <= ctrl_MULT;
                r_count  <= '0;
                r_acc    <= '0;
                r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_b_zero <= (data_operandB == c_ZERO);
                r_opnd   <= ctrl_MULT ? w_mag_a : w_mag_b;
                r_lo     <= ctrl_MULT ? w_mag_b[WIDTH-1:0] : w_mag_a[WIDTH-1:0];
            end else begin
                case (r_state)
                    ST_MUL: begin
                        r_acc <= {1'b0, w_sum[WIDTH:1]};
                        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                        if (r_count == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    ST_DIV: begin
                        if (!w_diff[WIDTH+1]) begin
                            r_acc <= w_diff[WIDTH:0];
                            r_lo  <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_shift;
                            r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                        if (r_count == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count + 6'd1;
                        end
                    end
                    ST_DONE: begin
                        // First DONE edge registers the result and raises
                        // ready; the second drops ready and goes idle.
                        if (!r_ready) begin
                            r_ready <= 1'b1;
                            if (r_is_mul) begin
                                r_result    <= w_signed_lo;
                                r_exception <= w_mul_ovf;
                            end else begin
                                r_result    <= r_b_zero ? c_ZERO : w_signed_lo;
                                r_exception <= w_div_exc;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Self-checking bench for multdiv_unit: directed multiply and
//                divide vectors, restart, simultaneous start, asynchronous
//                reset mid-operation and a back-to-back random run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_errors = 0;
    logic prev_rdy = 1'b0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Ready must never be high on two consecutive cycles.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            n_checks++;
            if (prev_rdy) begin
                n_errors++;
                $display("FAIL rdy_pulse: ready high two cycles in a row, actual 1 required 0");
            end
        end
        prev_rdy = data_resultRDY;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; issues one start and waits for ready.
    // Returns lat = -1 when no ready arrives within the budget.
    task automatic run_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc, output int lat);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV  = d;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (data_resultRDY) break;
        end
        if (!data_resultRDY) lat = -1;
        res = data_result;
        exc = data_exception;
    endtask

    function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_state: actual %h/%b/%b required 00000000/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_release: actual %h/%b/%b required 00000000/0/0",
                     data_result, data_exception, data_resultRDY);
        end
    endtask

    task automatic test_mult();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        logic        ve [8];
        logic [31:0] res;
        logic        exc;
        int          lat;
        va = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_8000, 32'h0000_8000};
        vb = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h0001_0000};
        vr = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'h8000_0000,
               32'd1, 32'h0, 32'h8000_0000, 32'h8000_0000};
        ve = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 1'b0, va[i], vb[i], res, exc, lat);
            n_checks++;
            if (lat !== 33) begin
                n_errors++;
                $display("FAIL mul_latency[%0d]: actual %0d required 33", i, lat);
            end
            n_checks++;
            if (res !== vr[i] || exc !== ve[i]) begin
                n_errors++;
                $display("FAIL mul_result[%0d] %h*%h: actual %h/%b required %h/%b",
                         i, va[i], vb[i], res, exc, vr[i], ve[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vr [8];
        logic        ve [8];
        logic [31:0] res;
        logic        exc;
        int          lat;
        va = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd100,
               32'hFFFF_FF9C, 32'd7, 32'h8000_0000, 32'd0};
        vb = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7,
               32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd1, 32'd5};
        vr = '{32'hFFFF_FFFD, 32'h0, 32'h8000_0000, 32'd14,
               32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0};
        ve = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, 1'b1, va[i], vb[i], res, exc, lat);
            n_checks++;
            if (lat !== 33) begin
                n_errors++;
                $display("FAIL div_latency[%0d]: actual %0d required 33", i, lat);
            end
            n_checks++;
            if (res !== vr[i] || exc !== ve[i]) begin
                n_errors++;
                $display("FAIL div_result[%0d] %h/%h: actual %h/%b required %h/%b",
                         i, va[i], vb[i], res, exc, vr[i], ve[i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          early = 0;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) early++;
        end
        run_op(1'b1, 1'b0, 32'd6, 32'd7, res, exc, lat);
        n_checks++;
        if (early !== 0 || lat !== 33) begin
            n_errors++;
            $display("FAIL restart_latency: actual early=%0d lat=%0d required early=0 lat=33", early, lat);
        end
        n_checks++;
        if (res !== 32'd42 || exc !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_result: actual %h/%b required 0000002a/0", res, exc);
        end
        early = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_errors++;
            $display("FAIL restart_extra_ready: actual %0d pulses required 0", early);
        end
    endtask

    task automatic test_both_start();
        logic [31:0] res;
        logic        exc;
        int          lat;
        run_op(1'b1, 1'b1, 32'd6, 32'd7, res, exc, lat);
        n_checks++;
        if (res !== 32'd42 || exc !== 1'b0 || lat !== 33) begin
            n_errors++;
            $display("FAIL both_start: actual %h/%b lat=%0d required 0000002a/0 lat=33", res, exc, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          seen = 0;
        data_operandA = 32'd123;
        data_operandB = 32'd456;
        ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_mid_async: actual %h/%b/%b required 00000000/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (data_resultRDY) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_no_ready: actual %0d pulses required 0", seen);
        end
        run_op(1'b1, 1'b0, 32'd123, 32'd456, res, exc, lat);
        n_checks++;
        if (res !== 32'd56088 || exc !== 1'b0 || lat !== 33) begin
            n_errors++;
            $display("FAIL reset_mid_recover: actual %h/%b lat=%0d required 0000db18/0 lat=33", res, exc, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res, er;
        logic        exc, ee, m;
        int          lat;
        for (int i = 0; i < 120; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($signed(6'($urandom)));
                1: a = 32'($signed(12'($urandom)));
                2: b = 32'd0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            model(m, a, b, er, ee);
            run_op(m, ~m, a, b, res, exc, lat);
            n_checks++;
            if (res !== er || exc !== ee || lat !== 33) begin
                n_errors++;
                $display("FAIL b2b[%0d] %s %h,%h: actual %h/%b lat=%0d required %h/%b lat=33",
                         i, m ? "MUL" : "DIV", a, b, res, exc, lat, er, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_restart();
        test_both_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
